alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Operations: ADD, SUB, AND, ORR and CMP at any WIDTH, plus an optional multi-cycle unsigned multiply.
- Operands are captured on an input handshake; results and flags are registered and held until the consumer takes them.
- Sits between the calculator control FSM and the result/display registers.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_seq_mul.sv | 64 ++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode field width, opcode values
// and the IDLE/MULT/DONE state encoding.
package alu_pkg;

  localparam int OPT_W = 3;

  localparam logic [OPT_W-1:0] OPT_NULL = 3'd0;
  localparam logic [OPT_W-1:0] OPT_ADD  = 3'd1;
  localparam logic [OPT_W-1:0] OPT_SUB  = 3'd2;
  localparam logic [OPT_W-1:0] OPT_AND  = 3'd3;
  localparam logic [OPT_W-1:0] OPT_ORR  = 3'd4;
  localparam logic [OPT_W-1:0] OPT_CMP  = 3'd5;
  localparam logic [OPT_W-1:0] OPT_MUL  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done and product describe the final iteration so the caller can register them on that edge.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  // Accumulator value after the current iteration.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  assign done    = busy && (cnt == CW'(1));
  assign product = acc_next;

  // Iteration state: load on start, then shift multiplicand left and multiplier right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH);
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU (ADD/SUB/AND/ORR/CMP) with registered, held results.
// Define ALU_SEQ_MUL_EN to add the multi-cycle unsigned multiply on opcode 6.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPT_W-1:0] opt,
  input  logic [WIDTH-1:0] numa,
  input  logic [WIDTH-1:0] numb,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             co,
  output logic             zero
);

  state_t           state;
  logic             accept;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] res;
  logic             res_co;

  assign accept = in_valid && in_ready;

  // Single-cycle result; the extra top bit of diff_ext is the borrow.
  always_comb begin
    sum_ext  = {1'b0, numa} + {1'b0, numb} + {{WIDTH{1'b0}}, ci};
    diff_ext = {1'b0, numa} - {1'b0, numb} - {{WIDTH{1'b0}}, ci};
    res      = '0;
    res_co   = 1'b0;
    case (opt)
      OPT_ADD: begin
        res    = sum_ext[WIDTH-1:0];
        res_co = sum_ext[WIDTH];
      end
      OPT_SUB, OPT_CMP: begin
        res    = diff_ext[WIDTH-1:0];
        res_co = diff_ext[WIDTH];
      end
      OPT_AND: begin
        res    = numa & numb;
        res_co = 1'b0;
      end
      OPT_ORR: begin
        res    = numa | numb;
        res_co = 1'b0;
      end
      OPT_NULL, OPT_MUL: begin
        res    = '0;
        res_co = 1'b0;
      end
      default: begin
        res    = '0;
        res_co = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   s_hi_q;

  assign mul_start = accept && (opt == OPT_MUL);
  assign s_hi      = s_hi_q;

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (numa),
    .b      (numb),
    .done   (mul_done),
    .product(product)
  );
`else
  assign s_hi = '0;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      zero      <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      s_hi_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (opt == OPT_MUL) begin
              state <= MULT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              s         <= res;
              s_hi_q    <= '0;
              co        <= res_co;
              zero      <= ~|res;
            end
`else
            state     <= DONE;
            out_valid <= 1'b1;
            s         <= res;
            co        <= res_co;
            zero      <= ~|res;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MULT: begin
          if (mul_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            s         <= product[WIDTH-1:0];
            s_hi_q    <= product[2*WIDTH-1:WIDTH];
            co        <= |product[2*WIDTH-1:WIDTH];
            zero      <= ~|product;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); honours ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] opt;
  logic [7:0] numa;
  logic [7:0] numb;
  logic       ci;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic [7:0] s_hi;
  logic       co;
  logic       zero;

  int n_checks;
  int n_errors;
  int lat;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opt      (opt),
    .numa     (numa),
    .numb     (numb),
    .ci       (ci),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .s_hi     (s_hi),
    .co       (co),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request; lat counts rising edges from the accept edge (inclusive) to out_valid.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    opt = op; numa = a; numb = b; ci = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; opt = 3'd0; numa = 8'h00; numb = 8'h00; ci = 1'b0;
    l = 1;
    while (!out_valid && l < 50) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic expect_res(input string tag, input int l, input int el, input logic [7:0] es,
                            input logic [7:0] eh, input logic ec, input logic ez);
    check({tag, "_lat"}, l, el);
    check({tag, "_s"}, {24'd0, s}, {24'd0, es});
    check({tag, "_s_hi"}, {24'd0, s_hi}, {24'd0, eh});
    check({tag, "_co"}, {31'd0, co}, {31'd0, ec});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; opt = 3'd0; numa = 8'h00; numb = 8'h00; ci = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {24'd0, s}, 32'd0);
    check("rst_s_hi", {24'd0, s_hi}, 32'd0);
    check("rst_co", {31'd0, co}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(3'd1, 8'hFF, 8'h01, 1'b0, lat);
    expect_res("add_wrap", lat, 1, 8'h00, 8'h00, 1'b1, 1'b1);
    check("add_wrap_in_ready", {31'd0, in_ready}, 32'd0);
    consume("add_wrap");

    run_op(3'd1, 8'h12, 8'h34, 1'b1, lat);
    expect_res("add_ci", lat, 1, 8'h47, 8'h00, 1'b0, 1'b0);
    consume("add_ci");

    run_op(3'd2, 8'h05, 8'h07, 1'b0, lat);
    expect_res("sub_borrow", lat, 1, 8'hFE, 8'h00, 1'b1, 1'b0);
    consume("sub_borrow");

    run_op(3'd2, 8'h10, 8'h05, 1'b1, lat);
    expect_res("sub_ci", lat, 1, 8'h0A, 8'h00, 1'b0, 1'b0);
    consume("sub_ci");

    run_op(3'd2, 8'h00, 8'hFF, 1'b1, lat);
    expect_res("sub_max_borrow", lat, 1, 8'h00, 8'h00, 1'b1, 1'b1);
    consume("sub_max_borrow");

    run_op(3'd5, 8'h42, 8'h42, 1'b0, lat);
    expect_res("cmp_eq", lat, 1, 8'h00, 8'h00, 1'b0, 1'b1);
    consume("cmp_eq");

    run_op(3'd4, 8'hA0, 8'h05, 1'b1, lat);
    expect_res("orr", lat, 1, 8'hA5, 8'h00, 1'b0, 1'b0);
    consume("orr");

`ifdef ALU_SEQ_MUL_EN
    run_op(3'd6, 8'h0F, 8'h11, 1'b1, lat);
    expect_res("mul_small", lat, 9, 8'hFF, 8'h00, 1'b0, 1'b0);
    consume("mul_small");
    run_op(3'd6, 8'hFF, 8'hFF, 1'b0, lat);
    expect_res("mul_max", lat, 9, 8'h01, 8'hFE, 1'b1, 1'b0);
    consume("mul_max");
`else
    run_op(3'd6, 8'hAA, 8'h55, 1'b1, lat);
    expect_res("op6_null", lat, 1, 8'h00, 8'h00, 1'b0, 1'b1);
    consume("op6_null");
`endif

    run_op(3'd7, 8'hAA, 8'h55, 1'b1, lat);
    expect_res("op7_null", lat, 1, 8'h00, 8'h00, 1'b0, 1'b1);
    consume("op7_null");

    // Backpressure: result held, new requests ignored while DONE
    run_op(3'd3, 8'hF0, 8'h3C, 1'b1, lat);
    expect_res("and_bp", lat, 1, 8'h30, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = (i != 1); opt = 3'd1; numa = 8'h01; numb = 8'h01;
      @(posedge clk);
      #1;
      check("bp_s", {24'd0, s}, 32'h30);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; opt = 3'd0; numa = 8'h00; numb = 8'h00;
    consume("and_bp");

    // out_ready with nothing pending
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ready_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Async reset in the middle of an operation
    @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
    opt = 3'd6; numa = 8'h0F; numb = 8'h11;
`else
    opt = 3'd1; numa = 8'h03; numb = 8'h04;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_s", {24'd0, s}, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd1, 8'h01, 8'h01, 1'b0, lat);
    expect_res("post_rst_add", lat, 1, 8'h02, 8'h00, 1'b0, 1'b0);
    consume("post_rst_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
